mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM register outputs (ALU result, rt store data, write-register address, branch target, zero flag, memory/WB control buses).
- Performs data-memory load/store (byte/half/word with sign/zero extension) and resolves branches.
- Drives the MEM/WB pipeline register; exposes a read-only debug port into data memory for the debug unit.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/data_memory_dp.sv | 29 ++
 rtl/mem_access_stage.sv | 100 ++++++++++
 tb/tb_mem_access_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline control-bus indices, load-size encodings and lane helpers
package mips_pkg;
  localparam int MEM_READ   = 0;
  localparam int MEM_WRITE  = 1;
  localparam int BRANCH     = 2;
  localparam int REG_WRITE  = 0;
  localparam int MEM_TO_REG = 1;
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } load_size_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? off[0] : |off;
  endfunction
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/data_memory_dp.sv
// data_memory_dp: simple dual-port byte-enable RAM, port A read/write, port B read-only
module data_memory_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_BITS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_a,
  input  logic                      we_a,
  input  logic [DATA_WIDTH/8-1:0]   be_a,
  input  logic [MEM_DEPTH_BITS-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0]     wdata_a,
  output logic [DATA_WIDTH-1:0]     q_a,
  input  logic                      en_b,
  input  logic [MEM_DEPTH_BITS-1:0] addr_b,
  output logic [DATA_WIDTH-1:0]     q_b
);
  logic [DATA_WIDTH-1:0] mem [0:2**MEM_DEPTH_BITS-1];
  // port A: lane-masked write and synchronous read that holds while disabled
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (we_a && be_a[i]) mem[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
    if (en_a) q_a <= mem[addr_a];
  end
  // port B: debug read, sees pre-write contents when colliding with port A
  always_ff @(posedge clk)
    if (!rst_n) q_b <= '0;
    else if (en_b) q_b <= mem[addr_b];
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with data memory access, branch resolve and MEM/WB register
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 32,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2,
  parameter int MEM_DEPTH_BITS = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_in,
  input  logic [MEM_BUS_WIDTH-1:0]  memory_bus_in,
  input  logic [WB_BUS_WIDTH-1:0]   wb_bus_in,
  input  logic [1:0]                load_size_in,
  input  logic                      load_unsigned_in,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     reg_rt_data_in,
  input  logic [DATA_WIDTH-1:0]     add_reg_w_in,
  input  logic [ADDR_BITS-1:0]      branch_pc_in,
  input  logic                      alu_zero_flag_in,
  output logic                      pc_src_out,
  output logic [ADDR_BITS-1:0]      branch_pc_out,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [DATA_WIDTH-1:0]     add_reg_w_out,
  output logic [WB_BUS_WIDTH-1:0]   wb_bus_out,
  output logic                      misaligned_out,
  input  logic                      dbg_rd_en,
  input  logic [MEM_DEPTH_BITS-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data_out,
  output logic                      dbg_valid_out
);
  logic                      mem_read, mem_write, branch, access_bad, we;
  logic [MEM_DEPTH_BITS-1:0] word_idx;
  logic [3:0]                be;
  logic [DATA_WIDTH-1:0]     wdata, ram_q;
  logic [7:0]                byte_sel;
  logic [15:0]               half_sel;
  logic                      rd_q, uns_q;
  logic [1:0]                off_q, size_q;
  // decode, store lane steering, load extraction/extension and branch resolve
  always_comb begin
    mem_read      = memory_bus_in[MEM_READ];
    mem_write     = memory_bus_in[MEM_WRITE];
    branch        = memory_bus_in[BRANCH];
    access_bad    = (mem_read | mem_write) & misaligned(load_size_in, alu_result_in[1:0]);
    we            = mem_write & ~access_bad & ~stall_in & rst_n;
    be            = lane_mask(load_size_in, alu_result_in[1:0]);
    word_idx      = alu_result_in[MEM_DEPTH_BITS+1:2];
    wdata         = load_size_in == SIZE_BYTE ? {4{reg_rt_data_in[7:0]}} :
                    load_size_in == SIZE_HALF ? {2{reg_rt_data_in[15:0]}} : reg_rt_data_in;
    byte_sel      = ram_q[{off_q, 3'b000} +: 8];
    half_sel      = off_q[1] ? ram_q[31:16] : ram_q[15:0];
    mem_data_out  = !rd_q ? '0 :
                    size_q == SIZE_BYTE ? {{(DATA_WIDTH-8){~uns_q & byte_sel[7]}}, byte_sel} :
                    size_q == SIZE_HALF ? {{(DATA_WIDTH-16){~uns_q & half_sel[15]}}, half_sel} : ram_q;
    pc_src_out    = branch & alu_zero_flag_in & ~stall_in;
    branch_pc_out = branch_pc_in;
  end
  // MEM/WB register plus registered load format and sticky misalignment flag
  always_ff @(posedge clk)
    if (!rst_n) begin
      alu_result_out <= '0;
      add_reg_w_out  <= '0;
      wb_bus_out     <= '0;
      misaligned_out <= 1'b0;
      rd_q           <= 1'b0;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
    end else if (!stall_in) begin
      alu_result_out <= alu_result_in;
      add_reg_w_out  <= add_reg_w_in;
      wb_bus_out     <= wb_bus_in;
      misaligned_out <= misaligned_out | access_bad;
      rd_q           <= mem_read & ~access_bad;
      off_q          <= alu_result_in[1:0];
      size_q         <= load_size_in;
      uns_q          <= load_unsigned_in;
    end
  // debug valid follows the request of the previous edge
  always_ff @(posedge clk)
    if (!rst_n) dbg_valid_out <= 1'b0;
    else dbg_valid_out <= dbg_rd_en;
  data_memory_dp #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH_BITS(MEM_DEPTH_BITS)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_a    (~stall_in),
    .we_a    (we),
    .be_a    (be),
    .addr_a  (word_idx),
    .wdata_a (wdata),
    .q_a     (ram_q),
    .en_b    (dbg_rd_en),
    .addr_b  (dbg_addr),
    .q_b     (dbg_data_out)
  );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed bench with a byte-array reference model of the MEM stage
module tb_mem_access_stage;
  logic        clk = 0, rst_n = 0, stall_in = 0;
  logic [2:0]  memory_bus_in = 0;
  logic [1:0]  wb_bus_in = 0, load_size_in = 0;
  logic        load_unsigned_in = 0, alu_zero_flag_in = 0, dbg_rd_en = 0;
  logic [31:0] alu_result_in = 0, reg_rt_data_in = 0, add_reg_w_in = 0, branch_pc_in = 0;
  logic [9:0]  dbg_addr = 0;
  logic        pc_src_out, misaligned_out, dbg_valid_out;
  logic [31:0] branch_pc_out, mem_data_out, alu_result_out, add_reg_w_out, dbg_data_out;
  logic [1:0]  wb_bus_out;
  int n_cmp = 0, n_bad = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .memory_bus_in(memory_bus_in),
    .wb_bus_in(wb_bus_in), .load_size_in(load_size_in), .load_unsigned_in(load_unsigned_in),
    .alu_result_in(alu_result_in), .reg_rt_data_in(reg_rt_data_in), .add_reg_w_in(add_reg_w_in),
    .branch_pc_in(branch_pc_in), .alu_zero_flag_in(alu_zero_flag_in), .pc_src_out(pc_src_out),
    .branch_pc_out(branch_pc_out), .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
    .add_reg_w_out(add_reg_w_out), .wb_bus_out(wb_bus_out), .misaligned_out(misaligned_out),
    .dbg_rd_en(dbg_rd_en), .dbg_addr(dbg_addr), .dbg_data_out(dbg_data_out),
    .dbg_valid_out(dbg_valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: byte-addressed memory with per-byte written flags
  logic [7:0]  m [0:4095];
  bit          kn [0:4095];
  logic [31:0] e_alu = 0, e_reg = 0, e_md = 0, e_dd = 0;
  logic [1:0]  e_wb = 0;
  logic        e_mis = 0, e_dv = 0;
  bit          e_md_kn = 1, e_dd_kn = 1;

  always @(posedge clk) begin : model
    int a, n;
    logic bad, rd, wr;
    logic [31:0] v;
    bit k;
    if (!rst_n) begin
      e_alu = 0; e_reg = 0; e_wb = 0; e_mis = 0; e_md = 0; e_md_kn = 1;
      e_dv = 0; e_dd = 0; e_dd_kn = 1;
    end else begin
      e_dv = dbg_rd_en;
      if (dbg_rd_en) begin
        v = 0; k = 1;
        for (int j = 0; j < 4; j++) begin
          v |= 32'(m[int'(dbg_addr) * 4 + j]) << (8 * j);
          k &= kn[int'(dbg_addr) * 4 + j];
        end
        e_dd = v; e_dd_kn = k;
      end
      if (!stall_in) begin
        rd = memory_bus_in[0];
        wr = memory_bus_in[1];
        a = int'(alu_result_in[11:0]);
        n = load_size_in == 2'b00 ? 1 : load_size_in == 2'b01 ? 2 : 4;
        bad = (rd | wr) && (a % n != 0);
        v = 0; k = 1;
        if (rd && !bad) begin
          for (int j = 0; j < n; j++) begin
            v |= 32'(m[a + j]) << (8 * j);
            k &= kn[a + j];
          end
          if (!load_unsigned_in && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
        end
        e_md = v; e_md_kn = k;
        if (wr && !bad)
          for (int j = 0; j < n; j++) begin
            m[a + j] = reg_rt_data_in[8 * j +: 8];
            kn[a + j] = 1;
          end
        if (bad) e_mis = 1;
        e_alu = alu_result_in; e_reg = add_reg_w_in; e_wb = wb_bus_in;
      end
    end
  end

  always @(negedge clk) begin
    chk("alu_result_out", alu_result_out, e_alu);
    chk("add_reg_w_out", add_reg_w_out, e_reg);
    chk("wb_bus_out", wb_bus_out, e_wb);
    chk("misaligned_out", misaligned_out, e_mis);
    if (e_md_kn) chk("mem_data_out", mem_data_out, e_md);
    chk("dbg_valid_out", dbg_valid_out, e_dv);
    if (e_dv && e_dd_kn) chk("dbg_data_out", dbg_data_out, e_dd);
    chk("pc_src_out", pc_src_out, memory_bus_in[2] & alu_zero_flag_in & ~stall_in);
    chk("branch_pc_out", branch_pc_out, branch_pc_in);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] d);
    memory_bus_in = {1'b0, wr, rd};
    wb_bus_in = rd ? 2'b11 : 2'b00;
    load_size_in = sz;
    load_unsigned_in = uns;
    alu_result_in = a;
    reg_rt_data_in = d;
    add_reg_w_in = 32'(a[6:2]);
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst misaligned", misaligned_out, 0);
    chk("rst mem_data", mem_data_out, 0);
    chk("rst wb_bus", wb_bus_out, 0);
    chk("rst dbg_valid", dbg_valid_out, 0);
    chk("rst dbg_data", dbg_data_out, 0);
    rst_n = 1;
    op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    op(1, 0, 2'b10, 0, 32'h10, 0);
    chk("lw deadbeef", mem_data_out, 32'hDEADBEEF);
    chk("lw wb_bus", wb_bus_out, 2'b11);
    op(0, 1, 2'b10, 0, 32'h10, 0);
    op(0, 1, 2'b00, 0, 32'h13, 32'h80);
    op(1, 0, 2'b00, 0, 32'h13, 0);
    chk("lb 0x13", mem_data_out, 32'hFFFFFF80);
    op(1, 0, 2'b00, 1, 32'h13, 0);
    chk("lbu 0x13", mem_data_out, 32'h00000080);
    op(1, 0, 2'b10, 0, 32'h10, 0);
    chk("lw after sb", mem_data_out, 32'h80000000);
    op(0, 1, 2'b00, 0, 32'h11, 32'h123456A5);
    op(1, 0, 2'b10, 0, 32'h10, 0);
    chk("lw after sb lane1", mem_data_out, 32'h8000A500);
    op(1, 0, 2'b01, 0, 32'h12, 0);
    chk("lh 0x12", mem_data_out, 32'hFFFF8000);
    op(1, 0, 2'b01, 1, 32'h12, 0);
    chk("lhu 0x12", mem_data_out, 32'h00008000);
    op(1, 0, 2'b10, 0, 32'h1010, 0);
    chk("lw wrap", mem_data_out, 32'h8000A500);
    chk("aligned no flag", misaligned_out, 0);
    op(1, 0, 2'b01, 0, 32'h11, 0);
    chk("lh misaligned data", mem_data_out, 0);
    chk("lh misaligned flag", misaligned_out, 1);
    op(0, 1, 2'b10, 0, 32'h12, 32'h55);
    op(1, 0, 2'b10, 0, 32'h10, 0);
    chk("sw misaligned suppressed", mem_data_out, 32'h8000A500);
    chk("flag sticky", misaligned_out, 1);
    rst_n = 0;
    op(0, 0, 2'b10, 0, 0, 0);
    chk("flag cleared", misaligned_out, 0);
    rst_n = 1;
    memory_bus_in = 3'b100; alu_zero_flag_in = 1; branch_pc_in = 32'h40;
    #1 chk("branch taken", pc_src_out, 1);
    chk("branch target", branch_pc_out, 32'h40);
    alu_zero_flag_in = 0;
    #1 chk("branch zero=0", pc_src_out, 0);
    alu_zero_flag_in = 1; stall_in = 1;
    #1 chk("branch stalled", pc_src_out, 0);
    stall_in = 0; alu_zero_flag_in = 0; memory_bus_in = 0;
    op(0, 1, 2'b10, 0, 32'h20, 32'h11111111);
    op(1, 0, 2'b10, 0, 32'h10, 0);
    stall_in = 1;
    op(0, 1, 2'b10, 0, 32'h20, 32'h55);
    chk("stall holds alu", alu_result_out, 32'h10);
    chk("stall holds data", mem_data_out, 32'h8000A500);
    stall_in = 0;
    op(1, 0, 2'b10, 0, 32'h20, 0);
    chk("stall no write", mem_data_out, 32'h11111111);
    dbg_rd_en = 1; dbg_addr = 4;
    op(0, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D);
    chk("dbg old data", dbg_data_out, 32'h8000A500);
    chk("dbg valid", dbg_valid_out, 1);
    op(0, 0, 2'b10, 0, 0, 0);
    chk("dbg new data", dbg_data_out, 32'hCAFEF00D);
    dbg_rd_en = 0;
    tick();
    chk("dbg valid drop", dbg_valid_out, 0);
    rst_n = 0;
    op(0, 1, 2'b10, 0, 32'h10, 32'h12345678);
    rst_n = 1;
    op(1, 0, 2'b10, 0, 32'h10, 0);
    chk("write under reset", mem_data_out, 32'hCAFEF00D);
    op(0, 0, 2'b10, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
